// File: rtl/vga_rx_monitor.sv
// Sink-side timing monitor for the 800x600 @ 40 MHz VGA stream: sync recovery, timing checks, lock FSM.
// Optional VGA_RX_CRC_EN builds a per-frame CRC-16-CCITT over active pixels; otherwise crc16 is tied to 0.
module vga_rx_monitor #(
  parameter int LINE_PERIOD = 1056,
  parameter int H_SYNC      = 128,
  parameter int H_TOL       = 2,
  parameter int H_DE_START  = 216,
  parameter int H_ACTIVE    = 800,
  parameter int FRAME_LINES = 628,
  parameter int V_DE_START  = 27,
  parameter int V_ACTIVE    = 600,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        Clk_40mhz,
  input  logic        RSTn,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [4:0]  red_in,
  input  logic [5:0]  green_in,
  input  logic [4:0]  blue_in,
  input  logic        err_clr,
  output logic        locked,
  output logic        frame_done,
  output logic [10:0] line_period_meas,
  output logic [10:0] hsync_width_meas,
  output logic [9:0]  frame_lines_meas,
  output logic [19:0] lit_count,
  output logic [3:0]  err_flags,
  output logic [15:0] crc16,
  output logic [1:0]  dbg_state
);

  localparam logic [10:0] LP     = 11'(LINE_PERIOD);
  localparam logic [10:0] HS_MIN = 11'(H_SYNC - H_TOL);
  localparam logic [10:0] HS_MAX = 11'(H_SYNC + H_TOL);
  localparam logic [10:0] HDE_LO = 11'(H_DE_START);
  localparam logic [10:0] HDE_HI = 11'(H_DE_START + H_ACTIVE);
  localparam logic [9:0]  FL     = 10'(FRAME_LINES);
  localparam logic [9:0]  VDE_LO = 10'(V_DE_START);
  localparam logic [9:0]  VDE_HI = 10'(V_DE_START + V_ACTIVE);
  // The x counter saturates at 2047, so a timeout beyond that clamps to the saturation value.
  localparam int          TO_INT = (2 * LINE_PERIOD > 2047) ? 2047 : 2 * LINE_PERIOD;
  localparam logic [10:0] TO_X   = 11'(TO_INT);
  localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic        frame_err_q, frame_err_d;
  logic        done_d;

  logic        hs_q, hs_qq, vs_q, vs_qq, err_clr_q;
  logic [4:0]  r_q, r_qq;
  logic        hs_fall, hs_rise, vs_fall;
  logic [10:0] x_q, x_inc;
  logic [9:0]  line_q;
  logic        period_armed_q, h_seen_q, v_seen_q, to_armed_q;
  logic        ev_period, ev_width, ev_lines, ev_timeout, any_err;
  logic [3:0]  err_ev;
  logic        active, lose_lock;
  logic [19:0] acc_q;

  assign hs_fall = hs_qq & ~hs_q;
  assign hs_rise = ~hs_qq & hs_q;
  assign vs_fall = vs_qq & ~vs_q;
  assign x_inc   = x_q + 11'd1;

  assign ev_period  = hs_fall & period_armed_q & (x_inc != LP);
  assign ev_width   = hs_rise & h_seen_q & ((x_inc < HS_MIN) | (x_inc > HS_MAX));
  assign ev_lines   = vs_fall & v_seen_q & (line_q != FL);
  assign ev_timeout = ~hs_fall & to_armed_q & (x_q == TO_X);
  assign err_ev     = {ev_timeout, ev_lines, ev_width, ev_period};
  assign any_err    = |err_ev;

  assign active = (x_q >= HDE_LO) && (x_q < HDE_HI) && (line_q >= VDE_LO) && (line_q < VDE_HI);

  assign locked    = (state_q == LOCKED);
  assign dbg_state = state_q;
  assign lose_lock = (state_q != UNLOCKED) && (state_d == UNLOCKED);

  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    frame_err_d = frame_err_q | any_err;
    done_d      = 1'b0;
    case (state_q)
      UNLOCKED: begin
        frame_err_d = 1'b0;
        if (vs_fall && !ev_timeout) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (ev_timeout) begin
          state_d = UNLOCKED;
          good_d  = '0;
        end else if (vs_fall) begin
          done_d      = 1'b1;
          frame_err_d = 1'b0;
          if (frame_err_q || any_err) begin
            good_d = '0;
          end else if (good_q + 8'd1 >= LOCK_N) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 8'd1;
          end
        end
      end
      LOCKED: begin
        if (vs_fall) begin
          done_d      = 1'b1;
          frame_err_d = 1'b0;
        end
        if (any_err) state_d = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge Clk_40mhz) begin
    if (!RSTn) begin
      hs_q             <= 1'b1;
      hs_qq            <= 1'b1;
      vs_q             <= 1'b1;
      vs_qq            <= 1'b1;
      err_clr_q        <= 1'b0;
      r_q              <= '0;
      r_qq             <= '0;
      x_q              <= '0;
      line_q           <= '0;
      period_armed_q   <= 1'b0;
      h_seen_q         <= 1'b0;
      v_seen_q         <= 1'b0;
      to_armed_q       <= 1'b0;
      acc_q            <= '0;
      line_period_meas <= '0;
      hsync_width_meas <= '0;
      frame_lines_meas <= '0;
      lit_count        <= '0;
      err_flags        <= '0;
      frame_done       <= 1'b0;
      state_q          <= UNLOCKED;
      good_q           <= '0;
      frame_err_q      <= 1'b0;
    end else begin
      hs_q      <= hsync_in;
      hs_qq     <= hs_q;
      vs_q      <= vsync_in;
      vs_qq     <= vs_q;
      err_clr_q <= err_clr;
      r_q       <= red_in;
      // Second pixel stage keeps the pixel aligned with x/line, which see edges one stage late.
      r_qq      <= r_q;

      if (hs_fall)               x_q <= '0;
      else if (x_q != 11'h7FF)   x_q <= x_inc;

      if (hs_rise) hsync_width_meas <= x_inc;
      if (hs_fall) begin
        line_period_meas <= x_inc;
        h_seen_q         <= 1'b1;
        to_armed_q       <= 1'b1;
        period_armed_q   <= 1'b1;
      end
      if (ev_timeout) to_armed_q <= 1'b0;
      if (lose_lock || ev_timeout) period_armed_q <= 1'b0;

      if (vs_fall)      line_q <= '0;
      else if (hs_fall) line_q <= line_q + 10'd1;

      if (vs_fall) begin
        frame_lines_meas <= line_q;
        v_seen_q         <= 1'b1;
      end

      if (vs_fall)
        acc_q <= '0;
      else if (active && (r_qq != 5'd0) && (acc_q != 20'hFFFFF))
        acc_q <= acc_q + 20'd1;
      if (done_d) lit_count <= acc_q;

      err_flags   <= (err_clr_q ? 4'd0 : err_flags) | err_ev;
      frame_done  <= done_d;
      state_q     <= state_d;
      good_q      <= good_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [5:0]  g_q, g_qq;
  logic [4:0]  b_q, b_qq;
  logic [15:0] crc_q;

  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [15:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  always_ff @(posedge Clk_40mhz) begin
    if (!RSTn) begin
      g_q   <= '0;
      g_qq  <= '0;
      b_q   <= '0;
      b_qq  <= '0;
      crc_q <= '0;
      crc16 <= '0;
    end else begin
      g_q  <= green_in;
      g_qq <= g_q;
      b_q  <= blue_in;
      b_qq <= b_q;
      if (vs_fall)     crc_q <= 16'hFFFF;
      else if (active) crc_q <= crc_step(crc_q, {r_qq, g_qq, b_qq});
      if (done_d) crc16 <= crc_q;
    end
  end
`else
  logic unused_color;
  assign unused_color = ^{green_in, blue_in};
  assign crc16 = '0;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Scoreboarded bench for vga_rx_monitor using a shrunken timing profile so whole frames stay short.
module tb_vga_rx_monitor;

  localparam int LP    = 40;
  localparam int HS    = 6;
  localparam int HTOL  = 2;
  localparam int HDS   = 10;
  localparam int HA    = 20;
  localparam int FL    = 20;
  localparam int VDS   = 3;
  localparam int VA    = 12;
  localparam int LOCKF = 2;
  localparam int VOFF  = 2;
  localparam int LIT   = 39;

  logic        Clk_40mhz;
  logic        RSTn;
  logic        hsync_in, vsync_in, err_clr;
  logic [4:0]  red_in;
  logic [5:0]  green_in;
  logic [4:0]  blue_in;
  logic        locked, frame_done;
  logic [10:0] line_period_meas, hsync_width_meas;
  logic [9:0]  frame_lines_meas;
  logic [19:0] lit_count;
  logic [3:0]  err_flags;
  logic [15:0] crc16;
  logic [1:0]  dbg_state;

  vga_rx_monitor #(
    .LINE_PERIOD(LP), .H_SYNC(HS), .H_TOL(HTOL), .H_DE_START(HDS), .H_ACTIVE(HA),
    .FRAME_LINES(FL), .V_DE_START(VDS), .V_ACTIVE(VA), .LOCK_FRAMES(LOCKF)
  ) dut (
    .Clk_40mhz(Clk_40mhz), .RSTn(RSTn), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .err_clr(err_clr),
    .locked(locked), .frame_done(frame_done), .line_period_meas(line_period_meas),
    .hsync_width_meas(hsync_width_meas), .frame_lines_meas(frame_lines_meas),
    .lit_count(lit_count), .err_flags(err_flags), .crc16(crc16), .dbg_state(dbg_state)
  );

  // clock / reset
  initial Clk_40mhz = 1'b0;
  always #5 Clk_40mhz = ~Clk_40mhz;

  int n_checks = 0;
  int n_fail   = 0;
  // record: {locked, flags[3:0], width[10:0], period[10:0], lines[9:0], lit[19:0], crc[15:0]}
  logic [72:0] exp_q[$];
  logic [72:0] mon_rec;
  logic [15:0] cur_crc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

`ifdef VGA_RX_CRC_EN
  function automatic logic [15:0] gold_crc(input logic [15:0] c_in, input logic [15:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  // 7x5 box of red=31, four active-window corners lit, four just-outside pixels lit.
  function automatic logic [4:0] red_at(input int j, input int i);
    if (j >= 5 && j <= 9 && i >= 12 && i <= 18) return 5'd31;
    if ((j == 3 || j == 14) && (i == 10 || i == 29)) return 5'd1;
    if ((j == 2 && i == 10) || (j == 15 && i == 10) || (j == 3 && i == 9) || (j == 3 && i == 30))
      return 5'd7;
    return 5'd0;
  endfunction

  // driver tasks
  task automatic tick;
    @(posedge Clk_40mhz);
    #1;
  endtask

  task automatic drive_line(input int j, input int period, input int hsw, input bit clr);
    for (int i = 0; i < period; i++) begin
      hsync_in = (i < hsw) ? 1'b0 : 1'b1;
      if (j == 0 && i == VOFF) vsync_in = 1'b0;
      if (j == 2 && i == VOFF) vsync_in = 1'b1;
      red_in  = red_at(j, i);
      err_clr = clr && (i == 20);
`ifdef VGA_RX_CRC_EN
      if (j >= VDS && j < VDS + VA && i >= HDS && i < HDS + HA)
        cur_crc = gold_crc(cur_crc, {red_in, green_in, blue_in});
`endif
      tick;
    end
    err_clr = 1'b0;
  endtask

  // The Vsync fall inside line 0 closes the previous frame; its expectation is queued here.
  task automatic drive_frame(input int nlines, input int bad_line, input int bad_period,
                             input int bad_hsw, input bit clr, input bit exp_done,
                             input bit lk, input logic [3:0] fl, input int lines, input int wid);
    logic [15:0] exp_crc;
`ifdef VGA_RX_CRC_EN
    exp_crc = cur_crc;
`else
    exp_crc = 16'h0000;
`endif
    cur_crc = 16'hFFFF;
    if (exp_done)
      exp_q.push_back({lk, fl, 11'(wid), 11'(LP), 10'(lines), 20'(LIT), exp_crc});
    for (int j = 0; j < nlines; j++)
      drive_line(j, (j == bad_line) ? bad_period : LP, (j == bad_line) ? bad_hsw : HS,
                 clr && (j == 1));
  endtask

  // scoreboard monitor
  always @(negedge Clk_40mhz) begin
    if (RSTn && frame_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL frame_done: unexpected pulse got 1 expected 0");
      end else begin
        mon_rec = exp_q.pop_front();
        chk("sb_locked", 32'(locked), 32'(mon_rec[72]));
        chk("sb_err_flags", 32'(err_flags), 32'(mon_rec[71:68]));
        chk("sb_hsync_width", 32'(hsync_width_meas), 32'(mon_rec[67:57]));
        chk("sb_line_period", 32'(line_period_meas), 32'(mon_rec[56:46]));
        chk("sb_frame_lines", 32'(frame_lines_meas), 32'(mon_rec[45:36]));
        chk("sb_lit_count", 32'(lit_count), 32'(mon_rec[35:16]));
        chk("sb_crc16", 32'(crc16), 32'(mon_rec[15:0]));
      end
    end
  end

  initial begin
    RSTn = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; err_clr = 1'b0;
    red_in = '0; green_in = '0; blue_in = '0; cur_crc = 16'hFFFF;
    repeat (4) tick;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_line_period", 32'(line_period_meas), 0);
    chk("rst_hsync_width", 32'(hsync_width_meas), 0);
    chk("rst_frame_lines", 32'(frame_lines_meas), 0);
    chk("rst_lit_count", 32'(lit_count), 0);
    chk("rst_err_flags", 32'(err_flags), 0);
    chk("rst_crc16", 32'(crc16), 0);
    chk("rst_state", 32'(dbg_state), 0);
    RSTn = 1'b1;
    repeat (5) tick;

    // nominal acquisition: lock at close of the 2nd clean frame
    drive_frame(20, -1, LP, HS, 0, 0, 0, 4'd0, 0, 0);
    drive_frame(20, -1, LP, HS, 0, 1, 0, 4'd0, 20, HS);
    drive_frame(20, -1, LP, HS, 0, 1, 1, 4'd0, 20, HS);
    chk("lock_state", 32'(dbg_state), 2);

    // short line while locked
    drive_frame(20, 5, LP - 1, HS, 0, 1, 1, 4'd0, 20, HS);
    chk("short_line_locked", 32'(locked), 0);
    chk("short_line_flags", 32'(err_flags), 1);
    drive_frame(20, -1, LP, HS, 0, 0, 0, 4'd1, 0, 0);
    drive_frame(20, -1, LP, HS, 0, 1, 0, 4'd1, 20, HS);
    drive_frame(20, -1, LP, HS, 0, 1, 1, 4'd1, 20, HS);

    // err_clr, then Hsync width at the tolerance edge and just beyond it
    drive_frame(20, 19, LP, HS + HTOL, 1, 1, 1, 4'd1, 20, HS);
    chk("clr_flags", 32'(err_flags), 0);
    chk("width_edge_locked", 32'(locked), 1);
    drive_frame(20, 10, LP, HS + HTOL + 1, 0, 1, 1, 4'd0, 20, HS + HTOL);
    chk("width_err_flags", 32'(err_flags), 2);
    chk("width_err_locked", 32'(locked), 0);

    // one frame short by a line
    drive_frame(20, -1, LP, HS, 0, 0, 0, 4'd2, 0, 0);
    drive_frame(19, -1, LP, HS, 0, 1, 0, 4'd2, 20, HS);
    drive_frame(20, -1, LP, HS, 0, 1, 0, 4'd6, 19, HS);
    chk("short_frame_state", 32'(dbg_state), 1);
    drive_frame(20, -1, LP, HS, 0, 1, 0, 4'd6, 20, HS);
    drive_frame(20, -1, LP, HS, 0, 1, 1, 4'd6, 20, HS);

    // Hsync stuck high past the timeout
    hsync_in = 1'b1; red_in = '0;
    repeat (2 * LP + 20) tick;
    chk("timeout_flags", 32'(err_flags), 14);
    chk("timeout_locked", 32'(locked), 0);
    chk("timeout_state", 32'(dbg_state), 0);
    drive_frame(20, -1, LP, HS, 0, 0, 0, 4'd14, 0, 0);
    drive_frame(20, -1, LP, HS, 0, 1, 0, 4'd14, 20, HS);
    drive_frame(20, -1, LP, HS, 0, 1, 1, 4'd14, 20, HS);
    chk("relock_locked", 32'(locked), 1);

    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    repeat (2) tick;
    chk("final_clr_flags", 32'(err_flags), 0);
    repeat (5) tick;
    chk("exp_q_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
